disp_edit_ctrl: RTL and testbench
=================================

// Module: disp_edit_ctrl
// PURPOSE
//  Sequencer for the 4-digit seven-segment path of the calculator. Owns operand entry (cursor, per-digit
//  increment), decides which value the display shows (operand or result) and drives the mode/digit
//  controls of the blinking display driver. Sits between debounced buttons/calculator core and the
//  BCD-to-segment decoders.
// PARAMETERS
//  EDIT_TIMEOUT  10  tick pulses with no button activity in EDIT before auto-exit to IDLE
//  RESULT_HOLD   5   tick pulses a new result is shown before returning to IDLE
//  DIGIT_MAX     9   largest value a BCD digit takes during increment (wraps to 0 after it)
// PORTS
//  clk            in   1   system clock
//  rst_n          in   1   asynchronous active-low reset
//  tick           in   1   one-cycle timebase enable (about 1 Hz)
//  btn_edit       in   1   one-cycle pulse: enter EDIT / commit operand
//  btn_next       in   1   one-cycle pulse: move cursor to next digit
//  btn_inc        in   1   one-cycle pulse: increment digit under cursor
//  result_valid   in   1   one-cycle pulse: result is valid this cycle
//  result         in   16  result, 4 BCD nibbles, [3:0] = digit 0 (rightmost)
//  mode           out  2   display mode: 0 IDLE, 1 EDIT (blink), 2 RESULT
//  digit          out  2   cursor digit index (blinking digit when mode==1)
//  disp_value     out  16  BCD nibbles to the segment decoders
//  operand        out  16  committed operand, BCD
//  operand_valid  out  1   one-cycle pulse when operand committed
// BEHAVIOUR
//  Reset (async, rst_n low): state=IDLE, mode=0, digit=0, disp_value=0, operand=0, edit buffer=0,
//   operand_valid=0, timers=0. All outputs registered; each takes effect the cycle after its cause.
//  States: IDLE (mode 0, disp_value=operand), EDIT (mode 1, disp_value=edit buffer),
//   RESULT (mode 2, disp_value=latched result).
//  IDLE: btn_edit -> EDIT, edit buffer<=operand, digit<=0, timer cleared. result_valid -> RESULT.
//  EDIT: btn_inc -> nibble[digit] += 1; a nibble at DIGIT_MAX (or >DIGIT_MAX) becomes 0. No carry.
//   btn_next -> digit += 1 mod 4 (3 wraps to 0). btn_edit -> operand<=buffer, operand_valid=1 for
//   one cycle, -> IDLE. Any button clears timer; tick increments it; at EDIT_TIMEOUT -> IDLE with
//   buffer discarded (operand unchanged, no operand_valid).
//  EDIT + result_valid: result latched into pending register, state unchanged; on leaving EDIT
//   (commit or timeout) go to RESULT instead of IDLE, with the pending result displayed.
//  RESULT: tick increments hold timer; at RESULT_HOLD -> IDLE. New result_valid reloads result and
//   clears timer. btn_edit -> EDIT immediately (result display abandoned); other buttons ignored.
//  Simultaneous events, same cycle, priority: btn_edit > btn_next > btn_inc; only highest acted on.
//   result_valid always latched regardless of buttons. Button and timeout same cycle: button wins.
//  tick in same cycle as state entry is not counted. Timers saturate; never wrap.
//  mode 3 never driven. digit held at last cursor value outside EDIT.
// TESTING
//  Reset mid-EDIT with buffer 0x1234 -> next cycle mode=0, digit=0, disp_value=0, operand=0.
//  IDLE, btn_edit, 10x btn_inc on digit 0 -> nibble0 0->9->0; btn_edit -> operand=0x0000, pulse 1 cycle.
//  EDIT, 5x btn_next -> digit 0,1,2,3,0,1; btn_inc -> buffer=0x0010; commit -> operand=0x0010.
//  EDIT, 10 ticks no buttons -> mode=0, operand unchanged, operand_valid never high.
//  EDIT, result_valid result=0x0042, then btn_edit -> mode=2, disp_value=0x0042; 5 ticks -> mode=0.
//  EDIT, btn_edit+btn_next+btn_inc same cycle -> commit only, digit unchanged, buffer unchanged.

Source files
------------

// File: rtl/disp_edit_ctrl.sv
// Display/edit sequencer for the 4-digit seven-segment path: operand entry with cursor,
// choice of operand/result display, and mode/digit drive for the blinking display driver.
module disp_edit_ctrl #(
    parameter int unsigned EDIT_TIMEOUT = 10,
    parameter int unsigned RESULT_HOLD  = 5,
    parameter int unsigned DIGIT_MAX    = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        btn_edit,
    input  logic        btn_next,
    input  logic        btn_inc,
    input  logic        result_valid,
    input  logic [15:0] result,
    output logic [1:0]  mode,
    output logic [1:0]  digit,
    output logic [15:0] disp_value,
    output logic [15:0] operand,
    output logic        operand_valid
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StEdit   = 2'd1,
        StResult = 2'd2
    } state_e;

    localparam logic [7:0] EditTo  = 8'(EDIT_TIMEOUT);
    localparam logic [7:0] HoldTo  = 8'(RESULT_HOLD);
    localparam logic [3:0] DigMax  = 4'(DIGIT_MAX);

    state_e      state_q, state_d;
    logic [1:0]  digit_q, digit_d;
    logic [15:0] buf_q, buf_d;
    logic [15:0] operand_q, operand_d;
    logic [15:0] result_q, result_d;
    logic [15:0] disp_q, disp_d;
    logic        pend_q, pend_d;
    logic        ov_q, ov_d;
    logic [7:0]  timer_q, timer_d;

    logic [7:0]  timer_inc;
    logic [3:0]  nib;
    logic [3:0]  nib_idx;

    always_comb begin
        state_d   = state_q;
        digit_d   = digit_q;
        buf_d     = buf_q;
        operand_d = operand_q;
        result_d  = result_q;
        pend_d    = pend_q;
        timer_d   = timer_q;
        ov_d      = 1'b0;
        disp_d    = disp_q;

        timer_inc = (timer_q == 8'hFF) ? timer_q : timer_q + 8'd1;
        nib_idx   = {digit_q, 2'b00};
        nib       = buf_q[nib_idx +: 4];

        if (result_valid) begin
            result_d = result;
        end

        unique case (state_q)
            StIdle: begin
                if (btn_edit) begin
                    state_d = StEdit;
                    buf_d   = operand_q;
                    digit_d = 2'd0;
                    timer_d = 8'd0;
                    pend_d  = result_valid;
                end else if (result_valid) begin
                    state_d = StResult;
                    timer_d = 8'd0;
                end
            end
            StEdit: begin
                if (result_valid) begin
                    pend_d = 1'b1;
                end
                // Only the highest-priority button acts; any button beats a timeout.
                if (btn_edit) begin
                    operand_d = buf_q;
                    ov_d      = 1'b1;
                    state_d   = (pend_q || result_valid) ? StResult : StIdle;
                    timer_d   = 8'd0;
                    pend_d    = 1'b0;
                end else if (btn_next) begin
                    digit_d = digit_q + 2'd1;
                    timer_d = 8'd0;
                end else if (btn_inc) begin
                    buf_d[nib_idx +: 4] = (nib >= DigMax) ? 4'd0 : nib + 4'd1;
                    timer_d = 8'd0;
                end else if (tick) begin
                    if (timer_inc >= EditTo) begin
                        state_d = (pend_q || result_valid) ? StResult : StIdle;
                        timer_d = 8'd0;
                        pend_d  = 1'b0;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
            end
            StResult: begin
                if (btn_edit) begin
                    state_d = StEdit;
                    buf_d   = operand_q;
                    digit_d = 2'd0;
                    timer_d = 8'd0;
                    pend_d  = result_valid;
                end else if (result_valid) begin
                    timer_d = 8'd0;
                end else if (tick) begin
                    if (timer_inc >= HoldTo) begin
                        state_d = StIdle;
                        timer_d = 8'd0;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                timer_d = 8'd0;
            end
        endcase

        unique case (state_d)
            StEdit:   disp_d = buf_d;
            StResult: disp_d = result_d;
            default:  disp_d = operand_d;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            digit_q   <= 2'd0;
            buf_q     <= 16'd0;
            operand_q <= 16'd0;
            result_q  <= 16'd0;
            disp_q    <= 16'd0;
            pend_q    <= 1'b0;
            ov_q      <= 1'b0;
            timer_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            digit_q   <= digit_d;
            buf_q     <= buf_d;
            operand_q <= operand_d;
            result_q  <= result_d;
            disp_q    <= disp_d;
            pend_q    <= pend_d;
            ov_q      <= ov_d;
            timer_q   <= timer_d;
        end
    end

    assign mode          = state_q;
    assign digit         = digit_q;
    assign disp_value    = disp_q;
    assign operand       = operand_q;
    assign operand_valid = ov_q;

endmodule

// File: tb/tb_disp_edit_ctrl.sv
// Scoreboard bench for disp_edit_ctrl: stimulus queues the expected outputs for the cycle after
// each input vector; a negedge monitor pops and compares them.
module tb_disp_edit_ctrl;

    logic        clk;
    logic        rst_n;
    logic        tick;
    logic        btn_edit;
    logic        btn_next;
    logic        btn_inc;
    logic        result_valid;
    logic [15:0] result;
    logic [1:0]  mode;
    logic [1:0]  digit;
    logic [15:0] disp_value;
    logic [15:0] operand;
    logic        operand_valid;

    disp_edit_ctrl #(
        .EDIT_TIMEOUT(10),
        .RESULT_HOLD (5),
        .DIGIT_MAX   (9)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .btn_edit     (btn_edit),
        .btn_next     (btn_next),
        .btn_inc      (btn_inc),
        .result_valid (result_valid),
        .result       (result),
        .mode         (mode),
        .digit        (digit),
        .disp_value   (disp_value),
        .operand      (operand),
        .operand_valid(operand_valid)
    );

    typedef struct {
        int          stamp;
        string       name;
        logic [36:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   n_checks;
    int   n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every expectation whose cycle has arrived is compared against the live outputs.
    always @(negedge clk) begin
        exp_t        e;
        logic [36:0] act;
        while (exp_q.size() > 0 && exp_q[0].stamp <= cyc) begin
            e   = exp_q.pop_front();
            act = {mode, digit, disp_value, operand, operand_valid};
            n_checks = n_checks + 1;
            if (act === e.v) begin
                n_pass = n_pass + 1;
            end else begin
                $display("FAIL %s @cyc %0d: got mode=%0d digit=%0d disp=%h op=%h ov=%b, want mode=%0d digit=%0d disp=%h op=%h ov=%b",
                         e.name, cyc, act[36:35], act[34:33], act[32:17], act[16:1], act[0],
                         e.v[36:35], e.v[34:33], e.v[32:17], e.v[16:1], e.v[0]);
            end
        end
    end

    task automatic push_exp(input string name, input logic [1:0] m, input logic [1:0] d,
                            input logic [15:0] disp, input logic [15:0] op, input logic ov);
        exp_t e;
        e.stamp = cyc + 1;
        e.name  = name;
        e.v     = {m, d, disp, op, ov};
        exp_q.push_back(e);
    endtask

    task automatic step(input logic e, input logic n, input logic i, input logic t,
                        input logic rv, input logic [15:0] res, input string name,
                        input logic [1:0] m, input logic [1:0] d, input logic [15:0] disp,
                        input logic [15:0] op, input logic ov);
        @(negedge clk);
        btn_edit     = e;
        btn_next     = n;
        btn_inc      = i;
        tick         = t;
        result_valid = rv;
        result       = res;
        push_exp(name, m, d, disp, op, ov);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst_n        = 1'b0;
        btn_edit     = 1'b0;
        btn_next     = 1'b0;
        btn_inc      = 1'b0;
        tick         = 1'b0;
        result_valid = 1'b0;
        result       = 16'd0;
        push_exp(name, 2'd0, 2'd0, 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] v;
        n_checks     = 0;
        n_pass       = 0;
        rst_n        = 1'b0;
        btn_edit     = 1'b0;
        btn_next     = 1'b0;
        btn_inc      = 1'b0;
        tick         = 1'b0;
        result_valid = 1'b0;
        result       = 16'd0;

        do_reset("reset_init");

        // Digit 0 counts 1..9 then wraps to 0; commit gives operand 0 with a one-cycle pulse.
        step(1, 0, 0, 0, 0, 16'h0, "enter_edit", 2'd1, 2'd0, 16'h0000, 16'h0000, 1'b0);
        for (int k = 0; k < 10; k++) begin
            v = 16'((k + 1) % 10);
            step(0, 0, 1, 0, 0, 16'h0, "inc_wrap", 2'd1, 2'd0, v, 16'h0000, 1'b0);
        end
        step(1, 0, 0, 0, 0, 16'h0, "commit_zero", 2'd0, 2'd0, 16'h0000, 16'h0000, 1'b1);
        step(0, 0, 0, 0, 0, 16'h0, "pulse_end", 2'd0, 2'd0, 16'h0000, 16'h0000, 1'b0);

        // Cursor walk 1,2,3,0,1 then increment digit 1.
        step(1, 0, 0, 0, 0, 16'h0, "enter_edit2", 2'd1, 2'd0, 16'h0000, 16'h0000, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 0, 0, 0, 16'h0, "cursor", 2'd1, 2'((k + 1) % 4), 16'h0000, 16'h0000, 1'b0);
        end
        step(0, 0, 1, 0, 0, 16'h0, "inc_d1", 2'd1, 2'd1, 16'h0010, 16'h0000, 1'b0);
        step(1, 0, 0, 0, 0, 16'h0, "commit_10", 2'd0, 2'd1, 16'h0010, 16'h0010, 1'b1);
        step(0, 0, 0, 0, 0, 16'h0, "digit_held", 2'd0, 2'd1, 16'h0010, 16'h0010, 1'b0);

        // Timeout: edited buffer is discarded after 10 ticks, no operand pulse.
        step(1, 0, 0, 0, 0, 16'h0, "enter_edit3", 2'd1, 2'd0, 16'h0010, 16'h0010, 1'b0);
        step(0, 0, 1, 0, 0, 16'h0, "inc_d0", 2'd1, 2'd0, 16'h0011, 16'h0010, 1'b0);
        for (int k = 0; k < 9; k++) begin
            step(0, 0, 0, 1, 0, 16'h0, "tick_in_edit", 2'd1, 2'd0, 16'h0011, 16'h0010, 1'b0);
        end
        step(0, 0, 0, 1, 0, 16'h0, "timeout", 2'd0, 2'd0, 16'h0010, 16'h0010, 1'b0);
        step(0, 0, 0, 0, 0, 16'h0, "after_timeout", 2'd0, 2'd0, 16'h0010, 16'h0010, 1'b0);

        // Result arriving during EDIT is shown after commit, then held for 5 ticks.
        step(1, 0, 0, 0, 0, 16'h0, "enter_edit4", 2'd1, 2'd0, 16'h0010, 16'h0010, 1'b0);
        step(0, 0, 0, 0, 1, 16'h0042, "pend_result", 2'd1, 2'd0, 16'h0010, 16'h0010, 1'b0);
        step(1, 0, 0, 0, 0, 16'h0, "commit_to_res", 2'd2, 2'd0, 16'h0042, 16'h0010, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 1, 0, 16'h0, "res_hold", 2'd2, 2'd0, 16'h0042, 16'h0010, 1'b0);
        end
        step(0, 0, 0, 1, 0, 16'h0, "res_expire", 2'd0, 2'd0, 16'h0010, 16'h0010, 1'b0);

        // All three buttons at once: only the commit happens.
        step(1, 0, 0, 0, 0, 16'h0, "enter_edit5", 2'd1, 2'd0, 16'h0010, 16'h0010, 1'b0);
        step(0, 1, 0, 0, 0, 16'h0, "next_d1", 2'd1, 2'd1, 16'h0010, 16'h0010, 1'b0);
        step(0, 0, 1, 0, 0, 16'h0, "inc_to_20", 2'd1, 2'd1, 16'h0020, 16'h0010, 1'b0);
        step(1, 1, 1, 0, 0, 16'h0, "prio_commit", 2'd0, 2'd1, 16'h0020, 16'h0020, 1'b1);

        // IDLE result, ignored buttons, reload restarts the hold timer, btn_edit abandons.
        step(0, 0, 0, 0, 1, 16'h0777, "idle_result", 2'd2, 2'd1, 16'h0777, 16'h0020, 1'b0);
        step(0, 1, 1, 0, 0, 16'h0, "res_ignore_btn", 2'd2, 2'd1, 16'h0777, 16'h0020, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 1, 0, 16'h0, "res_tick", 2'd2, 2'd1, 16'h0777, 16'h0020, 1'b0);
        end
        step(0, 0, 0, 0, 1, 16'h0999, "res_reload", 2'd2, 2'd1, 16'h0999, 16'h0020, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 1, 0, 16'h0, "reload_hold", 2'd2, 2'd1, 16'h0999, 16'h0020, 1'b0);
        end
        step(0, 0, 0, 0, 0, 16'h0, "reload_still", 2'd2, 2'd1, 16'h0999, 16'h0020, 1'b0);
        step(1, 0, 0, 0, 0, 16'h0, "res_to_edit", 2'd1, 2'd0, 16'h0020, 16'h0020, 1'b0);

        // Build 0x1234 in the edit buffer, then reset mid-EDIT.
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 1, 0, 0, 16'h0, "build_d0", 2'd1, 2'd0, 16'h0021 + 16'(k), 16'h0020,
                 1'b0);
        end
        step(0, 1, 0, 0, 0, 16'h0, "build_n1", 2'd1, 2'd1, 16'h0024, 16'h0020, 1'b0);
        step(0, 0, 1, 0, 0, 16'h0, "build_d1", 2'd1, 2'd1, 16'h0034, 16'h0020, 1'b0);
        step(0, 1, 0, 0, 0, 16'h0, "build_n2", 2'd1, 2'd2, 16'h0034, 16'h0020, 1'b0);
        step(0, 0, 1, 0, 0, 16'h0, "build_d2a", 2'd1, 2'd2, 16'h0134, 16'h0020, 1'b0);
        step(0, 0, 1, 0, 0, 16'h0, "build_d2b", 2'd1, 2'd2, 16'h0234, 16'h0020, 1'b0);
        step(0, 1, 0, 0, 0, 16'h0, "build_n3", 2'd1, 2'd3, 16'h0234, 16'h0020, 1'b0);
        step(0, 0, 1, 0, 0, 16'h0, "build_d3", 2'd1, 2'd3, 16'h1234, 16'h0020, 1'b0);
        do_reset("reset_mid_edit");
        step(0, 0, 0, 0, 0, 16'h0, "post_reset", 2'd0, 2'd0, 16'h0000, 16'h0000, 1'b0);

        // Bounded drain of outstanding expectations.
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
            @(negedge clk);
        end
        @(negedge clk);
        n_checks = n_checks + 1;
        if (exp_q.size() == 0) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL drain: %0d expectations still queued, want 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
